// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Command front end for an external 8-bit combinational ALU.
//
// Flow of one command:
//   - A command is accepted over a valid/ready handshake while the sequencer is idle.
//   - Operands come from a small register file, or from an immediate for B.
//   - The operands and opcode are held on the ALU inputs for one execute cycle.
//   - The ALU result is written back to the register file.
//   - The result is returned, together with zero/negative flags, until the consumer takes it.

module alu_cmd_sequencer #(
    parameter int DW   = 8,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_srca,
    input  logic [AW-1:0] cmd_srcb,
    input  logic          cmd_use_imm,
    input  logic [DW-1:0] cmd_imm,
    input  logic [AW-1:0] cmd_dst,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_opcode,
    input  logic [DW-1:0] alu_out,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] rsp_dst,
    output logic          rsp_zero,
    output logic          rsp_neg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Result flag helpers.
    function automatic logic flag_zero(input logic [DW-1:0] d);
        return (d == {DW{1'b0}});
    endfunction

    function automatic logic flag_neg(input logic [DW-1:0] d);
        return d[DW-1];
    endfunction

    state_t        state_r;
    state_t        state_nxt_s;
    logic          accept_s;
    logic          cmd_ready_s;
    logic          rsp_valid_s;
    logic [DW-1:0] rd_a_s;
    logic [DW-1:0] rd_b_s;

    logic [DW-1:0] rf_r [NREG];
    logic [DW-1:0] opa_r;
    logic [DW-1:0] opb_r;
    logic [2:0]    op_r;
    logic [AW-1:0] dst_r;
    logic [DW-1:0] rsp_data_r;
    logic [AW-1:0] rsp_dst_r;
    logic          rsp_zero_r;
    logic          rsp_neg_r;

    // Handshake status decoded from the state only, so it never depends on the inputs.
    always_comb begin
        cmd_ready_s = 1'b0;
        rsp_valid_s = 1'b0;
        case (state_r)
            IDLE:    cmd_ready_s = 1'b1;
            RESP:    rsp_valid_s = 1'b1;
            default: begin
                cmd_ready_s = 1'b0;
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    assign cmd_ready = cmd_ready_s;
    assign rsp_valid = rsp_valid_s;
    assign accept_s  = cmd_valid & cmd_ready_s;

    // Operand fetch for the command being offered.
    // B selects between the immediate and the register file.
    always_comb begin
        rd_a_s = rf_r[cmd_srca];
        if (cmd_use_imm) begin
            rd_b_s = cmd_imm;
        end else begin
            rd_b_s = rf_r[cmd_srcb];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    // Execute always lasts exactly one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC:    state_nxt_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand/opcode capture on accept.
    // These registers feed the ALU directly and hold between commands.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_r <= {DW{1'b0}};
            opb_r <= {DW{1'b0}};
            op_r  <= 3'b000;
            dst_r <= {AW{1'b0}};
        end else if (accept_s) begin
            opa_r <= rd_a_s;
            opb_r <= rd_b_s;
            op_r  <= cmd_op;
            dst_r <= cmd_dst;
        end
    end

    assign alu_a      = opa_r;
    assign alu_b      = opb_r;
    assign alu_opcode = op_r;

    // Register file writeback at the end of execute.
    // Operands were already captured at accept, so the next command reads the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_r[i] <= {DW{1'b0}};
            end
        end else if (state_r == EXEC) begin
            rf_r[dst_r] <= alu_out;
        end
    end

    // Response capture at the end of execute.
    // The response is held unchanged while it waits for the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_r <= {DW{1'b0}};
            rsp_dst_r  <= {AW{1'b0}};
            rsp_zero_r <= 1'b0;
            rsp_neg_r  <= 1'b0;
        end else if (state_r == EXEC) begin
            rsp_data_r <= alu_out;
            rsp_dst_r  <= dst_r;
            rsp_zero_r <= flag_zero(alu_out);
            rsp_neg_r  <= flag_neg(alu_out);
        end
    end

    assign rsp_data = rsp_data_r;
    assign rsp_dst  = rsp_dst_r;
    assign rsp_zero = rsp_zero_r;
    assign rsp_neg  = rsp_neg_r;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer.
//
// - Contains a behavioural 8-bit ALU wired onto alu_*.
// - Contains a reference model of the register file.
// - Runs directed scenarios first, then randomized command traffic.

module tb_alu_cmd_sequencer;
    localparam int DW   = 8;
    localparam int NREG = 4;
    localparam int AW   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_srca;
    logic [AW-1:0] cmd_srcb;
    logic          cmd_use_imm;
    logic [DW-1:0] cmd_imm;
    logic [AW-1:0] cmd_dst;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_opcode;
    logic [DW-1:0] alu_out;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_dst;
    logic          rsp_zero;
    logic          rsp_neg;

    int n_cmp    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int last_acc = -1;
    int last_hold = 0;

    logic [DW-1:0] model [NREG];

    alu_cmd_sequencer #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_use_imm(cmd_use_imm),
        .cmd_imm(cmd_imm), .cmd_dst(cmd_dst),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_dst(rsp_dst), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg)
    );

    always #5 clk = ~clk;

    // Cycle counter used to measure the spacing between accepts.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return {a[6:0], 1'b0};
            default: return {1'b0, a[7:1]};
        endcase
    endfunction

    assign alu_out = alu_fn(alu_opcode, alu_a, alu_b);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic randomize_cmd_fields();
        cmd_op      = 3'($urandom);
        cmd_srca    = AW'($urandom);
        cmd_srcb    = AW'($urandom);
        cmd_use_imm = 1'($urandom);
        cmd_imm     = DW'($urandom);
        cmd_dst     = AW'($urandom);
    endtask

    // Apply reset for one edge and check the reset state.
    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst_rsp_dst", 32'(rsp_dst), 32'd0);
        check_eq("rst_rsp_flags", {30'd0, rsp_zero, rsp_neg}, 32'd0);
        check_eq("rst_alu_a", 32'(alu_a), 32'd0);
        check_eq("rst_alu_b", 32'(alu_b), 32'd0);
        check_eq("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        for (int i = 0; i < NREG; i++) model[i] = 8'h00;
        last_acc = -1;
    endtask

    // Offer a command until it is accepted (bounded).
    // Returns 1 if it was accepted.
    task automatic offer_cmd(input logic [2:0] op, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                             input logic ui, input logic [DW-1:0] imm, input logic [AW-1:0] dst,
                             output logic acc);
        logic ok;
        cmd_op = op; cmd_srca = sa; cmd_srcb = sb; cmd_use_imm = ui; cmd_imm = imm; cmd_dst = dst;
        cmd_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            ok = cmd_ready;
            @(posedge clk); #1;
            if (ok) acc = 1'b1;
        end
        cmd_valid = 1'b0;
        randomize_cmd_fields();
        if (!acc) check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    // Full command transaction with a response back-pressure of 'hold' cycles.
    task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                           input logic ui, input logic [DW-1:0] imm, input logic [AW-1:0] dst,
                           input int hold);
        logic acc;
        logic [DW-1:0] ea, eb, er;
        rsp_ready = (hold == 0);
        offer_cmd(op, sa, sb, ui, imm, dst, acc);
        if (!acc) return;

        if (last_acc >= 0) check_eq("accept_gap", 32'(cyc - last_acc), 32'(3 + last_hold));
        last_acc  = cyc;
        last_hold = hold;

        ea = model[sa];
        eb = ui ? imm : model[sb];
        er = alu_fn(op, ea, eb);
        model[dst] = er;

        check_eq("exec_alu_a", 32'(alu_a), 32'(ea));
        check_eq("exec_alu_b", 32'(alu_b), 32'(eb));
        check_eq("exec_alu_opcode", 32'(alu_opcode), 32'(op));
        check_eq("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("exec_cmd_ready", 32'(cmd_ready), 32'd0);

        @(posedge clk); #1;
        check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("rsp_data", 32'(rsp_data), 32'(er));
        check_eq("rsp_dst", 32'(rsp_dst), 32'(dst));
        check_eq("rsp_zero", 32'(rsp_zero), 32'(er == 8'h00));
        check_eq("rsp_neg", 32'(rsp_neg), 32'(er[7]));

        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'($urandom);
            @(posedge clk); #1;
            check_eq("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check_eq("hold_rsp", {rsp_neg, rsp_zero, 6'd0, 6'd0, rsp_dst, 8'd0, rsp_data},
                     {er[7], er == 8'h00, 6'd0, 6'd0, dst, 8'd0, er});
        end

        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    // Reset while a command is executing.
    // The command must be dropped with no writeback and no response.
    task automatic reset_in_exec(input logic [2:0] op, input logic [AW-1:0] sa, input logic [AW-1:0] dst);
        logic acc;
        rsp_ready = 1'b0;
        offer_cmd(op, sa, sa, 1'b0, 8'h00, dst, acc);
        if (!acc) return;
        check_eq("rexec_cmd_ready", 32'(cmd_ready), 32'd0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("rexec_no_rsp", 32'(rsp_valid), 32'd0);
            check_eq("rexec_idle", 32'(cmd_ready), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_op = 3'd0; cmd_srca = '0; cmd_srcb = '0; cmd_use_imm = 1'b0; cmd_imm = '0; cmd_dst = '0;
        for (int i = 0; i < NREG; i++) model[i] = 8'h00;
        @(posedge clk); #1;
        do_reset();

        // Directed scenarios.
        run_cmd(3'd0, 2'd0, 2'd0, 1'b1, 8'h05, 2'd1, 0);   // r1 = r0 + 5
        run_cmd(3'd1, 2'd0, 2'd0, 1'b1, 8'h01, 2'd2, 0);   // r2 = r0 - 1
        run_cmd(3'd6, 2'd1, 2'd0, 1'b0, 8'h00, 2'd3, 0);   // r3 = r1 << 1
        run_cmd(3'd4, 2'd3, 2'd1, 1'b0, 8'h00, 2'd3, 0);   // r3 = r3 ^ r1
        check_eq("dir_r3", 32'(model[3]), 32'h0F);
        run_cmd(3'd3, 2'd2, 2'd1, 1'b0, 8'h00, 2'd0, 5);   // held response
        reset_in_exec(3'd5, 2'd0, 2'd1);                   // r1 = not r0, dropped
        run_cmd(3'd0, 2'd1, 2'd0, 1'b1, 8'h00, 2'd2, 0);   // readback r1 (0)
        run_cmd(3'd0, 2'd0, 2'd0, 1'b1, 8'h05, 2'd1, 0);   // r1 = 5
        run_cmd(3'd1, 2'd1, 2'd1, 1'b0, 8'h00, 2'd1, 0);   // r1 = r1 - r1

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            run_cmd(3'($urandom), AW'($urandom), AW'($urandom), 1'($urandom),
                    DW'($urandom), AW'($urandom), int'($urandom_range(0, 3)));
        end

        // Readback of every register through an add of immediate zero.
        for (int r = 0; r < NREG; r++) begin
            run_cmd(3'd0, AW'(r), 2'd0, 1'b1, 8'h00, AW'(r), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
